button_conditioner: RTL

//  Independent per-channel debouncer for NUM_BTN push-buttons. Each channel has
//  its own synchroniser, stability counter and press/release state machine.

---
 rtl/button_conditioner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Per-channel push-button debouncer: 2-flop synchroniser, stability counter and
// press/release FSM per channel. Optional auto-repeat is enabled by BUTTON_REPEAT_EN.
module button_conditioner #(
  parameter int NUM_BTN       = 5,
  parameter int CNT_W         = 18,
  parameter int DEB_MAX       = 2**CNT_W - 1,
  parameter int RPT_W         = 24,
  parameter int REPEAT_DELAY  = 2**23,
  parameter int REPEAT_PERIOD = 2**21
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic [NUM_BTN-1:0]   buttons_in,
  output logic [NUM_BTN-1:0]   buttons_level,
  output logic [NUM_BTN-1:0]   buttons_press,
  output logic [NUM_BTN-1:0]   buttons_release,
  output logic [2*NUM_BTN-1:0] o_dbg_state
);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ARM_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_ARM_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] DEB_MAX_C = CNT_W'(DEB_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (DEB_MAX < 1 || DEB_MAX > 2**CNT_W - 1) begin : g_bad_deb_max
    $error("button_conditioner: DEB_MAX must be in 1 .. 2**CNT_W-1");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_DELAY < 1 ||
      REPEAT_DELAY > 2**RPT_W - 1 || REPEAT_PERIOD > 2**RPT_W - 1) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_DELAY/REPEAT_PERIOD must be >=1 and fit RPT_W");
  end

  // Raw inputs are asynchronous; s is the second synchroniser stage.
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= buttons_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    logic             w_s;
    logic             w_rpt_fire;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    assign w_s = r_sync2[g];

`ifdef BUTTON_REPEAT_EN
    // Delay phase counts to the first repeat, then period phase loops.
    // Counting only advances while held with s=1, so a release bounce freezes it.
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] r_rpt;
    logic             r_rpt_periodic;
    logic             w_rpt_run;

    assign w_rpt_run  = (r_state == ST_HELD) && w_s;
    assign w_rpt_fire = w_rpt_run &&
                        (r_rpt_periodic ? (r_rpt == RPT_PERIOD_LAST)
                                        : (r_rpt == RPT_DELAY_LAST));

    always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
        r_rpt          <= '0;
        r_rpt_periodic <= 1'b0;
      end else if (w_rpt_run) begin
        if (w_rpt_fire) begin
          r_rpt          <= '0;
          r_rpt_periodic <= 1'b1;
        end else begin
          r_rpt <= r_rpt + 1'b1;
        end
      end else if (r_state == ST_IDLE || r_state == ST_ARM_PRESS) begin
        r_rpt          <= '0;
        r_rpt_periodic <= 1'b0;
      end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_s) begin
              r_state <= ST_ARM_PRESS;
              r_cnt   <= CNT_ONE;
            end
          end
          ST_ARM_PRESS: begin
            if (!w_s) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == DEB_MAX_C) begin
              r_state <= ST_HELD;
              r_level <= 1'b1;
              r_press <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_HELD: begin
            if (!w_s) begin
              r_state <= ST_ARM_RELEASE;
              r_cnt   <= CNT_ONE;
            end else if (w_rpt_fire) begin
              r_press <= 1'b1;
            end
          end
          ST_ARM_RELEASE: begin
            if (w_s) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else if (r_cnt == DEB_MAX_C) begin
              r_state   <= ST_IDLE;
              r_level   <= 1'b0;
              r_release <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end
        endcase
      end
    end

    assign buttons_level[g]       = r_level;
    assign buttons_press[g]       = r_press;
    assign buttons_release[g]     = r_release;
    assign o_dbg_state[2*g +: 2]  = r_state;
  end

endmodule
